// File: rtl/fphub_srt_divider_hs_if.sv
// Operand/result handshake bundle for the HUB SRT divider.
// The master side issues operands and consumes results; the slave side is the divider.
interface fphub_srt_divider_hs_if #(
    parameter int E = 8,
    parameter int M = 23
);
    logic         in_valid;
    logic         in_ready;
    logic [E+M:0] x;
    logic [E+M:0] d;
    logic         out_valid;
    logic         out_ready;
    logic [E+M:0] res;
    logic [3:0]   flags;

    modport master (
        output in_valid, x, d, out_ready,
        input  in_ready, out_valid, res, flags
    );

    modport slave (
        input  in_valid, x, d, out_ready,
        output in_ready, out_valid, res, flags
    );
endinterface

// File: rtl/fphub_srt_divider_hs.sv
// Iterative radix-2 SRT divider for HUB floating point (res = x/d), one quotient digit per cycle.
// Special operands bypass the iteration; results are held until the consumer accepts them.
module fphub_srt_divider_hs #(
    parameter int E     = 8,
    parameter int M     = 23,
    parameter int ITERS = M + 3
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  abort,
    fphub_srt_divider_hs_if.slave bus,
    output logic                  busy
);
    localparam int W  = E + M + 1;
    localparam int WW = M + 5;
    localparam int CW = $clog2(ITERS);

    localparam logic [CW-1:0]        LAST   = CW'(ITERS - 1);
    // Remainder fixed point: sign, two integer bits, M+2 fraction bits.
    localparam logic signed [WW-1:0] HALF   = {3'b000, 1'b1, {(M+1){1'b0}}};
    localparam logic signed [WW-1:0] N_HALF = -HALF;
    localparam logic signed [E+1:0]  BIAS_S = {3'b000, {(E-1){1'b1}}};
    localparam logic signed [E+1:0]  EMAX   = {2'b00, {E{1'b1}}};
    localparam logic signed [E+1:0]  ONE_S  = {{(E+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_NORM,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [WW-1:0]  w_q, w_d;
    logic signed [WW-1:0]  md_q, md_d;
    logic [ITERS-1:0]      p_q, p_d;
    logic [ITERS-1:0]      n_q, n_d;
    logic                  sign_q, sign_d;
    logic signed [E+1:0]   e_q, e_d;
    logic [W-1:0]          res_q, res_d;
    logic [3:0]            flags_q, flags_d;

    logic                  xs, ds;
    logic [E-1:0]          xe, de;
    logic [M-1:0]          xm, dm;
    logic                  x_zero, x_inf, d_zero, d_inf;
    logic                  special, is_nan, sgn;
    logic [W-1:0]          spc_res;
    logic [3:0]            spc_flags;

    logic signed [WW-1:0]  t;
    logic [ITERS-1:0]      q_raw;
    logic [M-1:0]          mant;
    logic signed [E+1:0]   e_n;
    logic [W-1:0]          norm_res;
    logic [3:0]            norm_flags;
    logic                  unused_q_lsbs;

    assign xs = bus.x[W-1];
    assign xe = bus.x[W-2 -: E];
    assign xm = bus.x[M-1:0];
    assign ds = bus.d[W-1];
    assign de = bus.d[W-2 -: E];
    assign dm = bus.d[M-1:0];

    assign x_zero  = (xe == '0);
    assign x_inf   = (xe == '1);
    assign d_zero  = (de == '0);
    assign d_inf   = (de == '1);
    assign special = x_zero | x_inf | d_zero | d_inf;
    assign is_nan  = (x_zero & d_zero) | (x_inf & d_inf);
    assign sgn     = xs ^ ds;

    always_comb begin
        spc_res   = '0;
        spc_flags = '0;
        if (is_nan) begin
            spc_res   = {1'b0, {(W-1){1'b1}}};
            spc_flags = 4'b1000;
        end else if (x_inf) begin
            spc_res = {sgn, {E{1'b1}}, {M{1'b0}}};
        end else if (d_zero) begin
            spc_res   = {sgn, {E{1'b1}}, {M{1'b0}}};
            spc_flags = 4'b0100;
        end else begin
            spc_res = {sgn, {(W-1){1'b0}}};
        end
    end

    assign t = w_q <<< 1;

    // Non-redundant quotient, one ulp down when the last remainder went negative.
    always_comb begin
        q_raw      = p_q - n_q - {{(ITERS-1){1'b0}}, w_q[WW-1]};
        mant       = '0;
        e_n        = e_q;
        norm_res   = '0;
        norm_flags = '0;
        if (q_raw[ITERS-1]) begin
            mant = q_raw[ITERS-2 -: M];
        end else begin
            mant = q_raw[ITERS-3 -: M];
            e_n  = e_q - ONE_S;
        end
        if (e_n >= EMAX) begin
            norm_res   = {sign_q, {E{1'b1}}, {M{1'b0}}};
            norm_flags = 4'b0010;
        end else if (e_n[E+1] || (e_n == '0)) begin
            norm_res   = {sign_q, {(W-1){1'b0}}};
            norm_flags = 4'b0001;
        end else begin
            norm_res = {sign_q, e_n[E-1:0], mant};
        end
    end

    assign unused_q_lsbs = ^q_raw[ITERS-M-3:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        md_d    = md_q;
        p_d     = p_q;
        n_d     = n_q;
        sign_d  = sign_q;
        e_d     = e_q;
        res_d   = res_q;
        flags_d = flags_q;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sign_d = sgn;
                        cnt_d  = '0;
                        p_d    = '0;
                        n_d    = '0;
                        w_d    = {3'b000, 1'b1, xm, 1'b1};
                        md_d   = {2'b00, 1'b1, dm, 1'b1, 1'b0};
                        e_d    = $signed({2'b00, xe}) - $signed({2'b00, de}) + BIAS_S;
                        if (special) begin
                            res_d   = spc_res;
                            flags_d = spc_flags;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    if (t >= HALF) begin
                        w_d = t - md_q;
                        p_d = {p_q[ITERS-2:0], 1'b1};
                        n_d = {n_q[ITERS-2:0], 1'b0};
                    end else if (t < N_HALF) begin
                        w_d = t + md_q;
                        p_d = {p_q[ITERS-2:0], 1'b0};
                        n_d = {n_q[ITERS-2:0], 1'b1};
                    end else begin
                        w_d = t;
                        p_d = {p_q[ITERS-2:0], 1'b0};
                        n_d = {n_q[ITERS-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = ST_NORM;
                    end
                end
                ST_NORM: begin
                    res_d   = norm_res;
                    flags_d = norm_flags;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            md_q    <= '0;
            p_q     <= '0;
            n_q     <= '0;
            sign_q  <= 1'b0;
            e_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            md_q    <= md_d;
            p_q     <= p_d;
            n_q     <= n_d;
            sign_q  <= sign_d;
            e_q     <= e_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.res       = res_q;
    assign bus.flags     = flags_q;
    assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fphub_srt_divider_hs.sv
// Directed-vector bench for the HUB SRT divider (E=8, M=23, 26 digits).
// Expected results are hand-derived HUB quotients, truncated, with flags and latency.
module tb_fphub_srt_divider_hs;
    logic clk;
    logic rst_l;
    logic abort;
    logic busy;

    int n_checks;
    int n_fail;

    fphub_srt_divider_hs_if #(.E(8), .M(23)) ifc ();

    fphub_srt_divider_hs #(.E(8), .M(23), .ITERS(26)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .abort (abort),
        .bus   (ifc),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] xv, input logic [31:0] dv,
                          input logic [31:0] rv, input logic [3:0] fv, input int lat_exp);
        int lat;
        @(negedge clk);
        check_eq({tag, " in_ready"}, 32'(ifc.in_ready), 32'd1);
        ifc.x         = xv;
        ifc.d         = dv;
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        lat = 1;
        while (!ifc.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(lat_exp));
        check_eq({tag, " res"}, ifc.res, rv);
        check_eq({tag, " flags"}, 32'(ifc.flags), 32'(fv));
        @(posedge clk);
        #1;
        check_eq({tag, " released"}, 32'(ifc.out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        n_checks      = 0;
        n_fail        = 0;
        rst_l         = 1'b0;
        abort         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        ifc.x         = '0;
        ifc.d         = '0;

        repeat (2) @(negedge clk);
        check_eq("rst in_ready", 32'(ifc.in_ready), 32'd1);
        check_eq("rst out_valid", 32'(ifc.out_valid), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst res", ifc.res, 32'h0);
        check_eq("rst flags", 32'(ifc.flags), 32'd0);
        rst_l = 1'b1;

        run_op("4/2",          32'h40800000, 32'h40000000, 32'h40000000, 4'b0000, 28);
        run_op("1.5/1.5",      32'h3FC00000, 32'h3FC00000, 32'h3F800000, 4'b0000, 28);
        run_op("-4/2",         32'hC0800000, 32'h40000000, 32'hC0000000, 4'b0000, 28);
        run_op("1/3",          32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 28);
        run_op("3/-1 trunc",   32'h40400000, 32'hBF800000, 32'hC03FFFFF, 4'b0000, 28);
        run_op("1/0",          32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
        run_op("0/0",          32'h00000000, 32'h00000000, 32'h7FFFFFFF, 4'b1000, 1);
        run_op("inf/inf",      32'h7F800000, 32'h7F800000, 32'h7FFFFFFF, 4'b1000, 1);
        run_op("inf/-2",       32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 1);
        run_op("inf/-0",       32'h7F800000, 32'h80000000, 32'hFF800000, 4'b0000, 1);
        run_op("0/-2",         32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000, 1);
        run_op("-1/inf",       32'hBF800000, 32'h7F800000, 32'h80000000, 4'b0000, 1);
        run_op("subnorm/1",    32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1);
        run_op("ovf",          32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 28);
        run_op("unf",          32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 28);
        run_op("e=254",        32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 28);
        run_op("e=255",        32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b0010, 28);
        run_op("e=1",          32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 28);
        run_op("e=0",          32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28);

        // Backpressure: result held, and a waiting operand is not taken on the release edge.
        @(negedge clk);
        ifc.x         = 32'h40800000;
        ifc.d         = 32'h40000000;
        ifc.in_valid  = 1'b1;
        ifc.out_ready = 1'b0;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        seen = 0;
        while (!ifc.out_valid && seen < 200) begin
            @(posedge clk);
            #1;
            seen++;
        end
        check_eq("bp out_valid rise", 32'(ifc.out_valid), 32'd1);
        ifc.x        = 32'h3F800000;
        ifc.d        = 32'h00000000;
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp hold out_valid", 32'(ifc.out_valid), 32'd1);
            check_eq("bp hold res", ifc.res, 32'h40000000);
            check_eq("bp hold flags", 32'(ifc.flags), 32'd0);
            check_eq("bp hold in_ready", 32'(ifc.in_ready), 32'd0);
        end
        @(negedge clk);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp release out_valid", 32'(ifc.out_valid), 32'd0);
        check_eq("bp no bypass busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        check_eq("bp next out_valid", 32'(ifc.out_valid), 32'd1);
        check_eq("bp next res", ifc.res, 32'h7F800000);
        check_eq("bp next flags", 32'(ifc.flags), 32'b0100);
        @(posedge clk);
        #1;
        check_eq("bp next released", 32'(ifc.out_valid), 32'd0);

        // Abort mid-iteration, then abort in IDLE must refuse operands.
        @(negedge clk);
        ifc.x        = 32'h40800000;
        ifc.d        = 32'h40000000;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        check_eq("abort busy before", 32'(busy), 32'd1);
        check_eq("abort in_ready before", 32'(ifc.in_ready), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort in_ready", 32'(ifc.in_ready), 32'd1);
        check_eq("abort out_valid", 32'(ifc.out_valid), 32'd0);
        @(negedge clk);
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort idle no accept", 32'(busy), 32'd0);
        @(negedge clk);
        abort        = 1'b0;
        ifc.in_valid = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ifc.out_valid) seen++;
        end
        check_eq("abort no result", 32'(seen), 32'd0);
        run_op("after abort", 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28);

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        ifc.x        = 32'h40400000;
        ifc.d        = 32'h3F800000;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_l = 1'b0;
        #1;
        check_eq("midrst busy", 32'(busy), 32'd0);
        check_eq("midrst in_ready", 32'(ifc.in_ready), 32'd1);
        check_eq("midrst out_valid", 32'(ifc.out_valid), 32'd0);
        check_eq("midrst res", ifc.res, 32'h0);
        check_eq("midrst flags", 32'(ifc.flags), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        run_op("after reset", 32'h3FC00000, 32'h3FC00000, 32'h3F800000, 4'b0000, 28);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
